// File: rtl/wfi_sequencer_pkg.sv
// Shared types for the WFI sequencer.
// State encoding, privilege codes, timeout rule.
package wfi_sequencer_pkg;

  typedef enum logic {
    WFI_IDLE,
    WFI_WAIT
  } wfistate_t;

  localparam logic [1:0] M_MODE = 2'b11;
  localparam logic [1:0] S_MODE = 2'b01;
  localparam logic [1:0] U_MODE = 2'b00;

  function automatic logic timeoutRule(
    input logic       uSup,
    input logic       sSup,
    input logic       tw,
    input logic [1:0] priv
  );
    return uSup & ((tw & (priv != M_MODE)) |
                   (sSup & (priv == U_MODE)));
  endfunction

endpackage

// File: rtl/wfi_sequencer_if.sv
// Control bundle between the M stage and
// the WFI sequencer.
interface wfi_sequencer_if;
  logic       wfiM;
  logic       StallM;
  logic       FlushM;
  logic       PendingIntsM;
  logic [1:0] PrivilegeModeW;
  logic       STATUS_TW;
  logic       WFIStallM;
  logic       WFIRetireM;
  logic       WFITimeoutM;
  logic       WFIActiveM;

  modport master (
    output wfiM, StallM, FlushM,
    output PendingIntsM, PrivilegeModeW,
    output STATUS_TW,
    input  WFIStallM, WFIRetireM,
    input  WFITimeoutM, WFIActiveM
  );

  modport slave (
    input  wfiM, StallM, FlushM,
    input  PendingIntsM, PrivilegeModeW,
    input  STATUS_TW,
    output WFIStallM, WFIRetireM,
    output WFITimeoutM, WFIActiveM
  );
endinterface

// File: rtl/wfi_sequencer_wfisatcnt.sv
// Saturating wait counter: holds once the
// top bit sets so an endless wait never wraps.
module wfisatcnt #(
  parameter int Width = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [Width-1:0] count
);

  // count up until the top bit sets, then hold
  always_ff @(posedge clk) begin
    if (!reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (en && !count[Width-1])
      count <= count + 1'b1;
  end

endmodule

// File: rtl/wfi_sequencer.sv
// WFI sequencer: stalls M stage while waiting,
// retires on interrupt or traps on timeout.
module wfi_sequencer
  import wfi_sequencer_pkg::*;
#(
  parameter int WFI_TIMEOUT_BIT = 16,
  parameter int U_SUPPORTED     = 1,
  parameter int S_SUPPORTED     = 1
) (
  input logic clk,
  input logic reset,
  wfi_sequencer_if.slave bus
);

  localparam int CntW = WFI_TIMEOUT_BIT + 1;

  wfistate_t       state, nextState;
  logic [CntW-1:0] waitCount;
  logic            teReg, teNow;
  logic            accept;
  logic            cntClr, cntEn, teLoad;
  logic            stallC, retireC, timeoutC;

  assign accept = bus.wfiM & ~bus.StallM
                & ~bus.FlushM;

  assign teNow = timeoutRule(
    U_SUPPORTED != 0, S_SUPPORTED != 0,
    bus.STATUS_TW, bus.PrivilegeModeW);

  wfisatcnt #(.Width(CntW)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (cntClr),
    .en    (cntEn),
    .count (waitCount)
  );

  // state and latched timeout enable
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= WFI_IDLE;
      teReg <= 1'b0;
    end else begin
      state <= nextState;
      if (teLoad)
        teReg <= teNow;
    end
  end

  // next state and per-cycle outputs
  always_comb begin
    nextState = state;
    stallC    = 1'b0;
    retireC   = 1'b0;
    timeoutC  = 1'b0;
    cntClr    = 1'b0;
    cntEn     = 1'b0;
    teLoad    = 1'b0;
    unique case (state)
      WFI_IDLE: begin
        if (accept && bus.PendingIntsM) begin
          retireC = 1'b1;
        end else if (accept) begin
          stallC    = 1'b1;
          nextState = WFI_WAIT;
          cntClr    = 1'b1;
          teLoad    = 1'b1;
        end
      end
      WFI_WAIT: begin
        if (bus.FlushM) begin
          nextState = WFI_IDLE;
        end else if (bus.PendingIntsM) begin
          retireC   = 1'b1;
          nextState = WFI_IDLE;
        end else if (teReg &&
                     waitCount[WFI_TIMEOUT_BIT]) begin
          timeoutC  = 1'b1;
          nextState = WFI_IDLE;
        end else begin
          stallC = 1'b1;
          cntEn  = 1'b1;
        end
      end
      default: nextState = WFI_IDLE;
    endcase
  end

  assign bus.WFIStallM   = reset & stallC;
  assign bus.WFIRetireM  = reset & retireC;
  assign bus.WFITimeoutM = reset & timeoutC;
  assign bus.WFIActiveM  = reset &
                           (state == WFI_WAIT);

endmodule

// File: doc/wfi_sequencer.md
# wfi_sequencer

Sequences execution of a decoded WFI instruction in the Memory stage. It holds the pipeline while the hart waits for an interrupt, retires the WFI when an interrupt becomes pending, and raises a timeout trap request when the TW/U-mode timeout rule applies. It sits beside the privileged-instruction decoder in the privileged unit. Its outputs feed the hazard unit (stall) and the trap logic (illegal-instruction cause).

## Interface
Parameters:
- WFI_TIMEOUT_BIT, default 16: the timeout fires when bit WFI_TIMEOUT_BIT of the wait counter sets. Counter width is WFI_TIMEOUT_BIT+1.
- U_SUPPORTED, default 1: when 0, a timeout never fires.
- S_SUPPORTED, default 1: enables the U-mode timeout rule.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-low reset (0 = reset).
- wfiM  input  1  legal WFI decoded in M stage.
- StallM  input  1  M stage stalled by another source.
- FlushM  input  1  M stage flushed (trap, debug, or older redirect).
- PendingIntsM  input  1  OR of (MIP & MIE); used for wakeup independent of global xIE.
- PrivilegeModeW  input  2  current privilege (M=11, S=01, U=00).
- STATUS_TW  input  1  mstatus.TW.
- WFIStallM  output  1  hold the pipeline from F to M.
- WFIRetireM  output  1  one-cycle pulse: the WFI completes as a NOP.
- WFITimeoutM  output  1  one-cycle pulse: the WFI raises an illegal-instruction fault.
- WFIActiveM  output  1  state == WAIT.

## Operation
- States: IDLE, WAIT. An encoded 1-bit state register is sufficient.
- Accept = wfiM & ~StallM & ~FlushM, evaluated in IDLE only.
- TimeoutEn = U_SUPPORTED & ((STATUS_TW & PrivilegeModeW != M) | (S_SUPPORTED & PrivilegeModeW == U)).
  - TimeoutEn is sampled into a register on entry to WAIT and held constant throughout WAIT.
- IDLE:
  - Accept & PendingIntsM → WFIRetireM=1 in the same cycle, WFIStallM=0, stay in IDLE.
  - Accept & ~PendingIntsM → WFIStallM=1 in the same cycle. Next state is WAIT and the counter loads 0.
  - Otherwise all outputs are 0.
- WAIT: exit conditions are evaluated in this priority order.
  1. FlushM → IDLE. No pulse, WFIStallM=0.
  2. PendingIntsM → WFIRetireM=1, WFIStallM=0, next state IDLE.
  3. TimeoutEn & Count[WFI_TIMEOUT_BIT] → WFITimeoutM=1, WFIStallM=0, next state IDLE.
  4. Otherwise WFIStallM=1, Count += 1.
- Counter saturates: once the top bit is set it holds and never wraps. This matters when TimeoutEn=0, where the hart waits indefinitely.
- WFIRetireM and WFITimeoutM are mutually exclusive and never both 1.
- The counter is cleared on every entry to WAIT.

## Timing
- Reset (reset=0 at a clk edge):
  - State goes to IDLE, Count to 0, TimeoutEn register to 0.
  - All outputs are forced to 0 while reset=0, regardless of other inputs.
  - Reset during WAIT abandons the wait with no pulse.
- Combinational paths: the outputs depend on inputs in the same cycle (wfiM, FlushM, PendingIntsM) plus the state. There is no added latency on wakeup: the pulse and the stall release occur in the same cycle PendingIntsM rises.
- Immediate wakeup: an accepted WFI with an interrupt already pending retires with 0 stall cycles.
- Timeout latency: entry cycle E, then WAIT cycles E+1 onward with Count = 0, 1, 2, …
  - The timeout fires in the WAIT cycle where Count = 2^WFI_TIMEOUT_BIT, i.e. cycle E+1+2^WFI_TIMEOUT_BIT.
  - Total stall is 2^WFI_TIMEOUT_BIT+2 cycles including E and the fire cycle.
- Simultaneous events:
  - Interrupt and timeout in the same cycle → retire wins.
  - Flush and interrupt in the same cycle → flush wins, no pulse.
- StallM is ignored in WAIT: this block is the stall source there.

## Structure
- Shared cvw package holds:
  - typedef enum logic {WFI_IDLE, WFI_WAIT} wfistate_t.
  - Privilege encodings M_MODE, S_MODE, U_MODE.
- One natural sub-module: wfisatcnt, a saturating up-counter with a synchronous active-low reset, a synchronous clear, an enable, and width WFI_TIMEOUT_BIT+1.
- State register and next-state/output logic stay in wfi_sequencer.

## Test plan
All scenarios use WFI_TIMEOUT_BIT=4.
- Reset: hold reset=0 for 3 cycles with wfiM=1 → all outputs 0. Release → IDLE, WFIActiveM=0.
- Immediate wake: wfiM=1, PendingIntsM=1 → WFIRetireM=1 the same cycle, WFIStallM never 1.
- Wait then wake: accept WFI with no pending interrupt. Raise PendingIntsM in the 5th WAIT cycle → WFIStallM=1 for 5 cycles (entry plus 4 WAIT cycles). WFIRetireM=1 with WFIStallM=0 in the 5th WAIT cycle, then IDLE.
- Timeout: U-mode, S_SUPPORTED=1, no interrupt → WFITimeoutM=1 in WAIT cycle 17 (Count=16), then IDLE. M-mode with TW=1 → no timeout after 100 cycles, and the counter holds at 16.
- Priority: in WAIT cycle 17, PendingIntsM=1 → WFIRetireM=1 and WFITimeoutM=0. Separately, FlushM=1 together with PendingIntsM → both pulses 0, next state IDLE.
- Gating and abort: wfiM=1 with StallM=1 → no state change. Reset=0 asserted mid-WAIT → IDLE next cycle, no pulse.
